// File: rtl/axi_wr_queue_if.sv
// axi_wr_queue_if
//  Bundles the queue's data-path signals: the cache-side push port, the
//  show-ahead head port toward the AXI write master, status flags and the
//  forwarding probe.
//  Modports:
//    slave  - the queue itself (consumes push/out_ready/lookup_addr,
//             drives status, head and lookup results)
//    master - the user side (cache write-back path plus write master)
//  Parameters must match the ones given to axi_wr_queue.
interface axi_wr_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 27,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_en;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ovf_err;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;

  modport slave (
    input  push_en, push_addr, push_data, out_ready, lookup_addr,
    output full, empty, count, out_valid, out_addr, out_data, ovf_err,
           lookup_hit, lookup_data
  );

  modport master (
    output push_en, push_addr, push_data, out_ready, lookup_addr,
    input  full, empty, count, out_valid, out_addr, out_data, ovf_err,
           lookup_hit, lookup_data
  );
endinterface

// File: rtl/axi_wr_queue.sv
// axi_wr_queue
//  Posted-write queue between the cache write-back path and the AXI write
//  master. Holds (address, data) pairs in strict FIFO order and presents the
//  oldest one show-ahead on out_addr/out_data. A push while full is dropped and
//  latches the sticky ovf_err flag until reset.
//  Ports:
//    ACLK     - clock, rising edge
//    ARESETN  - asynchronous active-low reset
//    q        - axi_wr_queue_if.slave: push_en/push_addr/push_data in,
//               full/empty/count/out_valid/out_addr/out_data/ovf_err out,
//               out_ready in, lookup_addr in, lookup_hit/lookup_data out
//  Configuration macro:
//    WQ_FWD_EN - when defined, enables the store-forwarding probe
//                (lookup_addr -> lookup_hit/lookup_data). When undefined the
//                probe outputs are tied to zero and no comparators exist.
module axi_wr_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 27,
  parameter int DW    = 32
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  axi_wr_queue_if.slave   q
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [PW-1:0] occupancy;
  logic          is_full;
  logic          is_empty;
  logic          push_ok;
  logic          pop_ok;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  assign wr_idx    = wr_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];
  assign occupancy = wr_ptr - rd_ptr;

  // The extra pointer MSB distinguishes a full ring from an empty one.
  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);

  // A push while full is dropped even when a pop frees a slot on the same edge.
  assign push_ok = q.push_en && !is_full;
  assign pop_ok  = !is_empty && q.out_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q.ovf_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (q.push_en && is_full) q.ovf_err <= 1'b1;
    end
  end

  // Entry storage is deliberately not reset; the pointers define validity.
  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem_addr[wr_idx] <= q.push_addr;
      mem_data[wr_idx] <= q.push_data;
    end
  end

  assign q.full      = is_full;
  assign q.empty     = is_empty;
  assign q.count     = occupancy;
  assign q.out_valid = !is_empty;
  assign q.out_addr  = is_empty ? '0 : mem_addr[rd_idx];
  assign q.out_data  = is_empty ? '0 : mem_data[rd_idx];

`ifdef WQ_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [IW-1:0] fwd_idx;

  // Walk entries from oldest to youngest so the last match found is the
  // youngest one; only occupied slots take part.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_idx;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_idx + IW'(i);
      if ((PW'(i) < occupancy) && (mem_addr[fwd_idx] == q.lookup_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[fwd_idx];
      end
    end
  end

  assign q.lookup_hit  = fwd_hit;
  assign q.lookup_data = fwd_data;
`else
  logic unused_lookup;

  assign unused_lookup = ^q.lookup_addr;
  assign q.lookup_hit  = 1'b0;
  assign q.lookup_data = '0;
`endif
endmodule

// File: tb/tb_axi_wr_queue.sv
// tb_axi_wr_queue
//  Self-checking bench for axi_wr_queue (DEPTH=8, AW=27, DW=32). A queue-based
//  reference model predicts every output; directed scenarios are followed by a
//  randomized push/pop phase. Honors WQ_FWD_EN the same way the design does.
module tb_axi_wr_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 27;
  localparam int DW    = 32;

  logic ACLK;
  logic ARESETN;

  axi_wr_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  axi_wr_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .q       (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] model_addr [$];
  logic [DW-1:0] model_data [$];
  logic          model_ovf = 1'b0;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input logic [AW-1:0] la);
    int n;
    logic          exp_hit;
    logic [DW-1:0] exp_fwd;
    n       = model_addr.size();
    exp_hit = 1'b0;
    exp_fwd = '0;
`ifdef WQ_FWD_EN
    for (int i = 0; i < n; i++) begin
      if (model_addr[i] == la) begin
        exp_hit = 1'b1;
        exp_fwd = model_data[i];
      end
    end
`endif
    check_output("count",     64'(bus.count),     64'(n));
    check_output("empty",     64'(bus.empty),     64'(n == 0));
    check_output("full",      64'(bus.full),      64'(n == DEPTH));
    check_output("out_valid", 64'(bus.out_valid), 64'(n != 0));
    check_output("out_addr",  64'(bus.out_addr),  (n != 0) ? 64'(model_addr[0]) : 64'd0);
    check_output("out_data",  64'(bus.out_data),  (n != 0) ? 64'(model_data[0]) : 64'd0);
    check_output("ovf_err",   64'(bus.ovf_err),   64'(model_ovf));
    check_output("lookup_hit",  64'(bus.lookup_hit),  64'(exp_hit));
    check_output("lookup_data", 64'(bus.lookup_data), 64'(exp_fwd));
  endtask

  // Called at a falling edge: drive inputs, check current outputs, advance the
  // model by the coming rising edge, then move to the next falling edge.
  task automatic step(input logic pe, input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd, input logic rdy,
                      input logic [AW-1:0] la);
    int  n;
    logic do_pop;
    logic do_push;
    bus.push_en     = pe;
    bus.push_addr   = pa;
    bus.push_data   = pd;
    bus.out_ready   = rdy;
    bus.lookup_addr = la;
    #1;
    check_state(la);
    n       = model_addr.size();
    do_pop  = (n > 0) && rdy;
    do_push = pe && (n < DEPTH);
    if (pe && n == DEPTH) model_ovf = 1'b1;
    if (do_pop) begin
      void'(model_addr.pop_front());
      void'(model_data.pop_front());
    end
    if (do_push) begin
      model_addr.push_back(pa);
      model_data.push_back(pd);
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, rdy, '0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rl;
    ARESETN         = 1'b0;
    bus.push_en     = 1'b0;
    bus.push_addr   = '0;
    bus.push_data   = '0;
    bus.out_ready   = 1'b0;
    bus.lookup_addr = '0;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    check_state('0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    $display("[TB] ordering");
    step(1'b1, 27'h100, 32'hA, 1'b1, '0);
    step(1'b1, 27'h104, 32'hB, 1'b1, '0);
    step(1'b1, 27'h108, 32'hC, 1'b1, '0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("[TB] full and overflow");
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(27'h300 + 4 * i), DW'(32'h10 + i), 1'b0, '0);
    step(1'b1, 27'h200, 32'hFF, 1'b1, '0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("[TB] simultaneous push and pop");
    for (int i = 0; i < 4; i++) step(1'b1, AW'(27'h400 + 4 * i), DW'(32'h20 + i), 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, AW'(27'h500 + 4 * i), DW'(32'h30 + i), 1'b1, '0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("[TB] forwarding probe");
    step(1'b1, 27'h40, 32'h1, 1'b0, 27'h40);
    step(1'b1, 27'h44, 32'h2, 1'b0, 27'h40);
    step(1'b1, 27'h40, 32'h3, 1'b0, 27'h40);
    idle(1'b0);
    step(1'b0, '0, '0, 1'b0, 27'h48);
    step(1'b0, '0, '0, 1'b1, 27'h40);
    step(1'b0, '0, '0, 1'b1, 27'h40);
    step(1'b0, '0, '0, 1'b1, 27'h40);
    step(1'b0, '0, '0, 1'b0, 27'h48);

    $display("[TB] reset mid-stream");
    step(1'b1, 27'h600, 32'h61, 1'b0, '0);
    step(1'b1, 27'h604, 32'h62, 1'b0, '0);
    step(1'b1, 27'h608, 32'h63, 1'b0, '0);
    step(1'b1, 27'h60C, 32'h64, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, AW'(27'h700 + 4 * i), 32'h70, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    bus.out_ready = 1'b0;
    ARESETN = 1'b0;
    #1;
    check_output("rst_empty",     64'(bus.empty),     64'd1);
    check_output("rst_count",     64'(bus.count),     64'd0);
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_ovf_err",   64'(bus.ovf_err),   64'd0);
    model_addr.delete();
    model_data.delete();
    model_ovf = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    idle(1'b0);
    idle(1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, 15) * 4);
      if (model_addr.size() > 0 && $urandom_range(0, 1) == 1)
        rl = model_addr[$urandom_range(0, model_addr.size() - 1)];
      else
        rl = AW'($urandom_range(0, 15) * 4);
      step(1'($urandom_range(0, 1)), ra, DW'($urandom), 1'($urandom_range(0, 2) != 0), rl);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
